dk_peak_capture_mc: RTL
=======================

Name: dk_peak_capture_mc

Overview:
- Parametrised multichannel front-end for the detector ADC chain. It is the successor of the fixed 4-channel, 14-bit pulse/peak block.
- Per channel it subtracts a tracked baseline and streams the corrected pulse.
- It detects threshold crossings on any channel, captures per-channel peak maxima over a programmable stretch window, and emits one coincidence event with hit mask and peak sum over a valid/ready handshake.
- Adds three features the previous generation lacked: event backpressure, a dropped-event counter, and a built-in simulation pulse source.

Parameters:
- NCH, 4, channel count (1..16)
- DW, 14, ADC sample width (unsigned)
- SW, 8, stretch field width
- BASE_SHIFT, 4, baseline EMA shift (time constant 2^BASE_SHIFT samples)
- SIM_PERIOD, 256, simulation pulse period in ce-samples (power of two)
- SIM_AMP, 4000, simulation amplitude for channel 0

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ce  in  1  sample clock enable
- datain  in  NCH*DW  packed samples, channel i at [i*DW +: DW]
- stretch  in  SW  window length minus one
- threshold  in  DW  trigger level on corrected sample
- offset_en  in  1  enable baseline tracking
- offset_rst  in  1  clear baselines
- sim  in  1  select internal pulse source
- pulseout  out  NCH*(DW+2)  signed corrected samples
- pulsevalid  out  1  pulseout strobe
- peakout  out  NCH*DW  captured per-channel maxima
- peaksum  out  DW+clog2(NCH)  sum of peakout
- hitmask  out  NCH  channels whose max exceeded threshold
- peakvalid  out  1  event valid
- peakready  in  1  event accepted by consumer
- dropcount  out  16  saturating count of lost events

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. On reset, all outputs, baselines, counters and the sim phase clear to 0, and the FSM goes to IDLE.
- ce gating:
  - With ce=0, the datapath, baselines, FSM window counter and sim phase hold.
  - The handshake (peakvalid/peakready) and offset_rst act on every clk regardless of ce.
- Source select: sim=1 replaces datain.
  - Channel i sample = SIM_AMP>>i while sim phase < 4, else 0.
  - Sim phase increments per ce, wrapping modulo SIM_PERIOD.
- Pipeline:
  - Stage 1 registers the sample.
  - Stage 2 computes corr = stage1 − baseline as a signed DW+1 value, sign-extended to DW+2 on pulseout.
  - pulseout latency is 2 ce-cycles. pulsevalid = ce delayed 2 clk.
- Baseline, per channel:
  - Accumulator is DW+BASE_SHIFT bits; baseline = acc>>BASE_SHIFT.
  - Update acc += stage1 − baseline only when offset_en=1, FSM=IDLE and ce=1.
  - offset_rst=1 clears acc next clk and overrides offset_en.
- Peak value: pos = corr clamped to [0, 2^DW−1].
- FSM states IDLE, CAPTURE, EMIT:
  - IDLE→CAPTURE on a ce-cycle where any channel's stage-2 corr > threshold (strict, signed compare).
    - Latch threshold and stretch.
    - Load max_i = pos_i of the trigger sample.
    - Window counter = stretch.
  - In CAPTURE, on each ce: max_i = max(max_i, pos_i) and counter decrements. When counter is 0 on a ce-cycle, go to EMIT.
    - The window spans stretch+1 samples including the trigger sample. stretch=0 gives a 1-sample window.
  - On entry to EMIT:
    - peakout = max_i.
    - hitmask[i] = (max_i > latched threshold).
    - peaksum = Σmax_i at full width with no overflow.
    - peakvalid=1.
    - Outputs hold stable while peakvalid=1.
  - EMIT→IDLE on the clk where peakvalid & peakready. peakvalid drops next clk and peakout stays at its last value.
  - A ready already high on EMIT entry completes the transfer one clk later.
- Drops: while in EMIT, any ce-cycle with corr>threshold on any channel increments dropcount. It counts at most once per ce-cycle and saturates at 0xFFFF. Drops occurring in CAPTURE are not counted; those samples are absorbed into the window.
- Reset mid-event discards the event with no peakvalid. Changing threshold or stretch during CAPTURE does not affect the current event.

Test Plan:
- Reset: assert rst mid-CAPTURE → all outputs 0 asynchronously, no peakvalid after release, dropcount=0.
- Baseline tracking: NCH=4, BASE_SHIFT=4, offset_en=1, all channels constant 1000 for 400 ce → baseline exactly 1000, pulseout=0. Then offset_rst pulse → pulseout=1000 two cycles later.
- Capture: baseline 0, threshold 100, stretch 3, ch0 sequence 50,150,300,200,120,0, others 0 → single event with peakout ch0=300, others 0, hitmask=4'b0001, peaksum=300. peakvalid rises 1 clk after the 120 sample is at stage 2.
- Backpressure and drop: hold peakready=0 for 30 cycles and inject a second pulse of 500 on ch2 during EMIT → peakout unchanged, dropcount=1. Raising ready gives exactly one transfer; the next pulse is then captured normally.
- Negative / no-trigger: baseline 1000, sample 900 → pulseout = −100 (16'hFF9C), peak clamp 0, no event.
- Sim mode: sim=1, threshold 100, stretch 7, offset_en=0 → one event per 256 ce with peakout = 4000, 2000, 1000, 500, hitmask=4'b1111, peaksum=7500. ce held low for 10 clk mid-window stretches the window by exactly 10 clk.

Source files
------------

// File: rtl/dk_peak_capture_mc.sv
// dk_peak_capture_mc: multichannel baseline-corrected pulse stream with stretched
// per-channel peak capture and one coincidence event per window over valid/ready.
module dk_peak_capture_mc #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned DW         = 14,
    parameter int unsigned SW         = 8,
    parameter int unsigned BASE_SHIFT = 4,
    parameter int unsigned SIM_PERIOD = 256,
    parameter int unsigned SIM_AMP    = 4000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce,
    input  logic [NCH*DW-1:0]             datain,
    input  logic [SW-1:0]                 stretch,
    input  logic [DW-1:0]                 threshold,
    input  logic                          offset_en,
    input  logic                          offset_rst,
    input  logic                          sim,
    output logic [NCH*(DW+2)-1:0]         pulseout,
    output logic                          pulsevalid,
    output logic [NCH*DW-1:0]             peakout,
    output logic [DW+$clog2(NCH)-1:0]     peaksum,
    output logic [NCH-1:0]                hitmask,
    output logic                          peakvalid,
    input  logic                          peakready,
    output logic [15:0]                   dropcount
);

    localparam int unsigned CW   = DW + 1;
    localparam int unsigned AW   = DW + BASE_SHIFT;
    localparam int unsigned SUMW = DW + $clog2(NCH);
    localparam int unsigned PW   = (SIM_PERIOD > 1) ? $clog2(SIM_PERIOD) : 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, EMIT} state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          cnt_q, cnt_d;
    logic [DW-1:0]          thr_q, thr_d;
    logic [DW-1:0]          max_q [NCH];
    logic [DW-1:0]          max_d [NCH];
    logic [DW-1:0]          src   [NCH];
    logic [DW-1:0]          s1_q  [NCH];
    logic [DW-1:0]          base  [NCH];
    logic [DW-1:0]          pos   [NCH];
    logic [AW-1:0]          acc_q [NCH];
    logic signed [CW-1:0]   corr_q [NCH];
    logic signed [CW-1:0]   corr_d [NCH];
    logic [NCH-1:0]         over;
    logic [PW-1:0]          phase_q;
    logic                   sim_on;
    logic [1:0]             pv_q;
    logic                   emit_load, drop_inc;
    logic [NCH*DW-1:0]      peakout_d, peakout_q;
    logic [NCH-1:0]         hit_d, hitmask_q;
    logic [SUMW-1:0]        sum_d, peaksum_q;
    logic                   peakvalid_q;
    logic [15:0]            dropcount_q;

    assign sim_on = 32'(phase_q) < 32'd4;

    // Source select, baseline view, corrected sample, clamped peak value, trigger compare
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            src[i]    = sim ? (sim_on ? DW'(SIM_AMP >> i) : '0) : datain[i*DW +: DW];
            base[i]   = acc_q[i][AW-1:BASE_SHIFT];
            corr_d[i] = $signed({1'b0, s1_q[i]}) - $signed({1'b0, base[i]});
            pos[i]    = corr_q[i][DW] ? '0 : corr_q[i][DW-1:0];
            over[i]   = corr_q[i] > $signed({1'b0, threshold});
            pulseout[i*(DW+2) +: DW+2] = {corr_q[i][DW], corr_q[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            pv_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                s1_q[i]   <= '0;
                corr_q[i] <= '0;
                acc_q[i]  <= '0;
            end
        end else begin
            pv_q <= {pv_q[0], ce};
            if (ce) begin
                phase_q <= (32'(phase_q) == SIM_PERIOD - 1) ? '0 : phase_q + PW'(1);
            end
            for (int i = 0; i < NCH; i++) begin
                if (ce) begin
                    s1_q[i]   <= src[i];
                    corr_q[i] <= corr_d[i];
                end
                // Baseline only tracks between events so pulses do not bias it
                if (offset_rst) begin
                    acc_q[i] <= '0;
                end else if (offset_en && ce && (state_q == IDLE)) begin
                    acc_q[i] <= acc_q[i] + AW'(corr_d[i]);
                end
            end
        end
    end

    // Event FSM: trigger, stretch window, emit with handshake
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        thr_d     = thr_q;
        max_d     = max_q;
        emit_load = 1'b0;
        drop_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ce && (|over)) begin
                    thr_d = threshold;
                    cnt_d = stretch;
                    max_d = pos;
                    if (stretch == '0) begin
                        state_d   = EMIT;
                        emit_load = 1'b1;
                    end else begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (ce) begin
                    for (int i = 0; i < NCH; i++) begin
                        max_d[i] = (pos[i] > max_q[i]) ? pos[i] : max_q[i];
                    end
                    cnt_d = cnt_q - SW'(1);
                    if (cnt_q == SW'(1)) begin
                        state_d   = EMIT;
                        emit_load = 1'b1;
                    end
                end
            end
            EMIT: begin
                drop_inc = ce && (|over);
                if (peakvalid_q && peakready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Event payload computed from the post-update maxima
    always_comb begin
        peakout_d = '0;
        hit_d     = '0;
        sum_d     = '0;
        for (int i = 0; i < NCH; i++) begin
            peakout_d[i*DW +: DW] = max_d[i];
            hit_d[i]              = max_d[i] > thr_d;
            sum_d                 = sum_d + SUMW'(max_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            thr_q       <= '0;
            peakout_q   <= '0;
            hitmask_q   <= '0;
            peaksum_q   <= '0;
            peakvalid_q <= 1'b0;
            dropcount_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                max_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            max_q   <= max_d;
            if (emit_load) begin
                peakout_q   <= peakout_d;
                hitmask_q   <= hit_d;
                peaksum_q   <= sum_d;
                peakvalid_q <= 1'b1;
            end else if (peakvalid_q && peakready) begin
                peakvalid_q <= 1'b0;
            end
            if (drop_inc && (dropcount_q != 16'hFFFF)) begin
                dropcount_q <= dropcount_q + 16'd1;
            end
        end
    end

    assign pulsevalid = pv_q[1];
    assign peakout    = peakout_q;
    assign hitmask    = hitmask_q;
    assign peaksum    = peaksum_q;
    assign peakvalid  = peakvalid_q;
    assign dropcount  = dropcount_q;

endmodule
